arb8_rr: RTL and testbench
==========================

ARB8_RR -- requirements
Module: arb8_rr

Interface
REQ-001 Parameter HOLD_MAX, default 8, maximum consecutive cycles one requester SHALL own the grant (legal range 1..255).
REQ-002 clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  8  request vector, bit i = requester i wants the shared encoded resource.
REQ-005 gnt  output  8  one-hot grant vector, all-zero when no owner.
REQ-006 gnt_idx  output  3  binary index of the set gnt bit (8-to-3 encoding), 3'd0 when gnt_valid=0.
REQ-007 gnt_valid  output  1  high exactly when gnt is non-zero.

Function
REQ-008 The block SHALL implement a two-state FSM: IDLE (no owner) and BUSY (owner held); all outputs SHALL be registered.
REQ-009 IDLE with req=8'h00 SHALL remain IDLE with gnt=8'h00, gnt_idx=3'd0, gnt_valid=0.
REQ-010 IDLE with req!=0 SHALL select the winner as the first set req bit found searching upward from ptr, wrapping 7->0, and enter BUSY at the next edge.
REQ-011 Grant latency SHALL be exactly one cycle: req sampled at edge N yields gnt, gnt_idx, gnt_valid valid after edge N+1.
REQ-012 On every new grant, ptr SHALL load (winner+1) mod 8; ptr SHALL not change otherwise.
REQ-013 hold_cnt SHALL load 0 on the granting edge and increment by 1 on each edge spent in BUSY, saturating at no higher than HOLD_MAX-1.
REQ-014 BUSY SHALL release (go to IDLE, outputs cleared at next edge) when req[owner]=0 or hold_cnt=HOLD_MAX-1, whichever occurs first.
REQ-015 Release SHALL always insert exactly one IDLE cycle with gnt_valid=0 before any next grant (one-cycle bubble, no back-to-back handover).
REQ-016 Changes on req bits other than the owner's while BUSY SHALL NOT affect gnt, gnt_idx, or hold_cnt.
REQ-017 With HOLD_MAX=1 every grant SHALL last exactly one cycle.
REQ-018 gnt SHALL never have more than one bit set; gnt_idx SHALL always equal the encoded position of that bit.
REQ-019 Requests present only in the bubble cycle SHALL be arbitrated normally in that IDLE cycle (grant after the following edge).
REQ-020 Sustained all-ones req SHALL grant indices 0,1,2,...,7,0 in strict rotation after reset.

Reset
REQ-021 rst_n=0 SHALL immediately, without a clock edge, force state=IDLE, ptr=3'd0, hold_cnt=0, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0.
REQ-022 Reset asserted mid-BUSY SHALL drop the grant immediately and discard ownership; after release the first grant SHALL search from index 0.
REQ-023 Release of rst_n SHALL be synchronous-safe: the first state change SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-024 Single requester: req=8'h08 held 3 cycles then 8'h00 -> gnt=8'h08, gnt_idx=3'd3, gnt_valid=1 from edge 1 for 3 cycles, then all outputs 0.
REQ-025 Rotation: req=8'hFF constant, HOLD_MAX=2 -> gnt_idx sequence 0,0,-,1,1,-,2,2,-,...,7,7,-,0 ('-' = bubble, gnt_valid=0).
REQ-026 Wrap search: grant index 6 and release, then req=8'h41 -> next gnt_idx=3'd0 (search starts at 7, wraps to 0), not 6.
REQ-027 Hold timeout: req=8'h20 held continuously, HOLD_MAX=8 -> gnt=8'h20 exactly 8 cycles, one bubble, regrant of index 5 with gnt_idx=3'd5.
REQ-028 Async reset: req=8'h80 granted, pull rst_n low between edges -> gnt=8'h00, gnt_valid=0 before next edge; after release with req=8'h81 -> gnt_idx=3'd0.
REQ-029 Invariant check every cycle: gnt one-hot or zero, gnt_valid equals |gnt, gnt_idx equals encoding of gnt.

Source files
------------

// File: rtl/arb8_rr.sv
// arb8_rr: 8-way round-robin arbiter with bounded ownership.
// One owner at a time; an owner keeps the grant while its request stays high,
// up to HOLD_MAX cycles. Every release is followed by one idle bubble cycle
// before the next grant. All outputs are registered.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[7:0]   request vector, bit i = requester i
//   gnt[7:0]   one-hot grant, zero when no owner
//   gnt_idx    binary index of the granted requester, 0 when no owner
//   gnt_valid  high exactly when gnt is non-zero
module arb8_rr #(
   parameter int unsigned HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid
);

   localparam int unsigned N_REQ = 8;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N_REQ-1:0]   gnt_d;
   logic [IDX_W-1:0]   idx_d;
   logic               valid_d;

   logic               found;
   logic [IDX_W-1:0]   win;
   logic [IDX_W-1:0]   cand;

   // Round-robin search: first set request at or above ptr, wrapping 7->0.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = ptr_q + IDX_W'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt;
      idx_d   = gnt_idx;
      valid_d = gnt_valid;

      case (state_q)
         IDLE: begin
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            if (found) begin
               state_d = BUSY;
               ptr_d   = win + IDX_W'(1);
               cnt_d   = '0;
               gnt_d   = N_REQ'(1) << win;
               idx_d   = win;
               valid_d = 1'b1;
            end
         end
         BUSY: begin
            // Only the owner's request matters while busy.
            if (!req[gnt_idx] || (cnt_q == HOLD_LAST)) begin
               state_d = IDLE;
               gnt_d   = '0;
               idx_d   = '0;
               valid_d = 1'b0;
            end else begin
               // Release at HOLD_LAST keeps the counter below saturation.
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         gnt       <= gnt_d;
         gnt_idx   <= idx_d;
         gnt_valid <= valid_d;
      end
   end

endmodule

// File: tb/tb_arb8_rr.sv
// Testbench for arb8_rr: three instances (HOLD_MAX = 2, 8, 1) share clock,
// reset and request; each is compared every cycle against a behavioural
// model, plus directed scenario checks.
module tb_arb8_rr;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] gnt_o [3];
   logic [2:0] idx_o [3];
   logic       val_o [3];

   int hold_of [3] = '{2, 8, 1};
   int m_owner [3];
   int m_held  [3];
   int m_ptr   [3];

   int checks   = 0;
   int failures = 0;

   arb8_rr #(.HOLD_MAX(2)) u_h2 (.clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt_o[0]), .gnt_idx(idx_o[0]), .gnt_valid(val_o[0]));
   arb8_rr #(.HOLD_MAX(8)) u_h8 (.clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt_o[1]), .gnt_idx(idx_o[1]), .gnt_valid(val_o[1]));
   arb8_rr #(.HOLD_MAX(1)) u_h1 (.clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt_o[2]), .gnt_idx(idx_o[2]), .gnt_valid(val_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_owner[k] = -1;
         m_held[k]  = 0;
         m_ptr[k]   = 0;
      end
   endtask

   // Owner keeps the grant for at most HOLD_MAX cycles while requesting;
   // a released arbiter sits idle for the cycle that follows.
   task automatic model_step();
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 3; k++) begin
         if (m_owner[k] < 0) begin
            for (int j = 0; j < 8; j++) begin
               int c;
               c = (m_ptr[k] + j) % 8;
               if (m_owner[k] < 0 && req[c]) m_owner[k] = c;
            end
            if (m_owner[k] >= 0) begin
               m_held[k] = 1;
               m_ptr[k]  = (m_owner[k] + 1) % 8;
            end
         end else if (!req[m_owner[k]] || m_held[k] == hold_of[k]) begin
            m_owner[k] = -1;
         end else begin
            m_held[k]++;
         end
      end
   endtask

   function automatic logic [7:0] enc(input logic [7:0] g);
      for (int i = 0; i < 8; i++) if (g[i]) return 8'(i);
      return 8'd0;
   endfunction

   task automatic compare_all();
      for (int k = 0; k < 3; k++) begin
         logic [7:0] eg;
         eg = (m_owner[k] < 0) ? 8'h00 : (8'h01 << m_owner[k]);
         check($sformatf("gnt_h%0d", hold_of[k]), gnt_o[k], eg);
         check($sformatf("idx_h%0d", hold_of[k]), 8'(idx_o[k]),
               (m_owner[k] < 0) ? 8'd0 : 8'(m_owner[k]));
         check($sformatf("valid_h%0d", hold_of[k]), 8'(val_o[k]),
               (m_owner[k] < 0) ? 8'd0 : 8'd1);
         check($sformatf("onehot_h%0d", hold_of[k]), 8'($onehot0(gnt_o[k])), 8'd1);
         check($sformatf("vmatch_h%0d", hold_of[k]), 8'(val_o[k]), 8'(|gnt_o[k]));
         check($sformatf("imatch_h%0d", hold_of[k]), 8'(idx_o[k]), enc(gnt_o[k]));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1 compare_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1 compare_all();
      @(posedge clk);
      #1 compare_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      req   = 8'h00;
      model_reset();
      #2;
      do_reset();
      check("reset_gnt", gnt_o[1], 8'h00);
      check("reset_valid", 8'(val_o[1]), 8'd0);

      // Idle with no request.
      cycle();
      cycle();

      // Single requester 3 held cycles.
      req = 8'h08;
      for (int c = 0; c < 3; c++) begin
         cycle();
         check("single_gnt", gnt_o[1], 8'h08);
         check("single_idx", 8'(idx_o[1]), 8'd3);
      end
      req = 8'h00;
      cycle();
      check("single_release", gnt_o[1], 8'h00);
      cycle();

      // Rotation with HOLD_MAX=2: 0,0,-,1,1,-,...
      do_reset();
      req = 8'hFF;
      for (int c = 0; c < 27; c++) begin
         cycle();
         if (c % 3 < 2) begin
            check("rot_idx", 8'(idx_o[0]), 8'((c / 3) % 8));
            check("rot_valid", 8'(val_o[0]), 8'd1);
         end else begin
            check("rot_bubble", 8'(val_o[0]), 8'd0);
         end
         if (c < 16) check("rot_h1", 8'(idx_o[2]), (c % 2 == 0) ? 8'(c / 2) : 8'd0);
      end

      // Hold timeout with HOLD_MAX=8.
      do_reset();
      req = 8'h20;
      for (int c = 0; c < 10; c++) begin
         cycle();
         if (c < 8)       check("hold_gnt", gnt_o[1], 8'h20);
         else if (c == 8) check("hold_bubble", gnt_o[1], 8'h00);
         else             check("hold_regrant", 8'(idx_o[1]), 8'd5);
      end

      // Wrap search: grant 6, release, then 0 and 6 request together.
      req = 8'h00;
      cycle();
      cycle();
      req = 8'h40;
      cycle();
      check("wrap_first", 8'(idx_o[1]), 8'd6);
      req = 8'h00;
      cycle();
      req = 8'h41;
      cycle();
      check("wrap_idx", 8'(idx_o[1]), 8'd0);
      check("wrap_valid", 8'(val_o[1]), 8'd1);

      // Async reset mid-grant.
      req = 8'h00;
      cycle();
      cycle();
      req = 8'h80;
      cycle();
      check("ar_gnt", gnt_o[1], 8'h80);
      #2 rst_n = 1'b0;
      model_reset();
      #1 compare_all();
      check("ar_drop", gnt_o[1], 8'h00);
      check("ar_valid", 8'(val_o[1]), 8'd0);
      cycle();
      @(negedge clk);
      rst_n = 1'b1;
      req = 8'h81;
      cycle();
      check("ar_regrant", 8'(idx_o[1]), 8'd0);

      // Randomized traffic with occasional async reset pulses.
      for (int n = 0; n < 600; n++) begin
         int r;
         r = $urandom_range(0, 7);
         if (r == 0)      req = 8'h00;
         else if (r < 3)  req = req;
         else if (r < 6)  req = 8'($urandom) & 8'($urandom);
         else             req = 8'($urandom);
         if ($urandom_range(0, 59) == 0) begin
            #2 rst_n = 1'b0;
            model_reset();
            #1 compare_all();
            cycle();
            @(negedge clk);
            rst_n = 1'b1;
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
